// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and mode encodings for the 1-to-7 deserialiser
package demux_pkg;

  localparam int NUM_SLOTS_DEFAULT = 7;
  localparam int SEL_W_DEFAULT     = 3;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_AUTO = 1'b1;

endpackage

// File: rtl/demux_1to7_deser_slot_counter.sv
// rtl/demux_1to7_deser_slot_counter.sv - mod-N slot counter with explicit wrap
module slot_counter
  import demux_pkg::*;
#(
  parameter int N = NUM_SLOTS_DEFAULT,
  parameter int W = SEL_W_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] r_count;

  // Wrap is explicit so the count never reaches N even when N < 2**W.
  assign o_wrap  = i_inc && (r_count == W'(N - 1));
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= o_wrap ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/demux_1to7_deser.sv
// rtl/demux_1to7_deser.sv - serial bit steered into 7 registered slots, addressed or auto-sweep
module demux_1to7_deser
  import demux_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEFAULT,
  parameter int SEL_W     = SEL_W_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_din,
  input  logic                 i_din_valid,
  input  logic                 i_mode,
  input  logic [SEL_W-1:0]     i_sel,
  input  logic                 i_clear,
  output logic [NUM_SLOTS-1:0] o_slots,
  output logic [NUM_SLOTS-1:0] o_frame,
  output logic                 o_frame_valid,
  output logic [SEL_W-1:0]     o_slot_idx,
  output logic                 o_sel_err
);

  logic                 r_mode_q;
  logic [NUM_SLOTS-1:0] r_slots;
  logic [NUM_SLOTS-1:0] r_frame;
  logic                 r_frame_valid;
  logic                 r_sel_err;

  logic                 w_mode_chg;
  logic                 w_write;
  logic                 w_sel_ok;
  logic                 w_addr_wr;
  logic                 w_auto_wr;
  logic                 w_sel_bad;
  logic                 w_wrap;
  logic [SEL_W-1:0]     w_idx;
  logic [SEL_W-1:0]     w_tgt;
  logic [NUM_SLOTS-1:0] w_next_slots;

  // A mode change drops that cycle's bit and restarts the sweep.
  assign w_mode_chg = (i_mode != r_mode_q);
  assign w_write    = i_din_valid && !i_clear && !w_mode_chg;
  assign w_sel_ok   = (i_sel < SEL_W'(NUM_SLOTS));
  assign w_addr_wr  = w_write && (i_mode == MODE_ADDR) && w_sel_ok;
  assign w_sel_bad  = w_write && (i_mode == MODE_ADDR) && !w_sel_ok;
  assign w_auto_wr  = w_write && (i_mode == MODE_AUTO);
  assign w_tgt      = (i_mode == MODE_AUTO) ? w_idx : i_sel;

  slot_counter #(
    .N (NUM_SLOTS),
    .W (SEL_W)
  ) u_slot_counter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (i_clear || w_mode_chg),
    .i_inc   (w_auto_wr),
    .o_count (w_idx),
    .o_wrap  (w_wrap)
  );

  always_comb begin
    w_next_slots = r_slots;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if ((w_addr_wr || w_auto_wr) && (w_tgt == SEL_W'(i))) begin
        w_next_slots[i] = i_din;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    r_mode_q <= i_mode;
    if (i_reset) begin
      r_slots       <= '0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_sel_err     <= 1'b0;
    end else if (i_clear) begin
      r_slots       <= '0;
      r_frame_valid <= 1'b0;
      r_sel_err     <= 1'b0;
    end else begin
      r_slots       <= w_next_slots;
      r_frame_valid <= w_wrap;
      r_sel_err     <= w_sel_bad;
      // The completing bit is taken from w_next_slots so it lands in the frame.
      if (w_wrap) begin
        r_frame <= w_next_slots;
      end
    end
  end

  assign o_slots       = r_slots;
  assign o_frame       = r_frame;
  assign o_frame_valid = r_frame_valid;
  assign o_slot_idx    = w_idx;
  assign o_sel_err     = r_sel_err;

endmodule

// File: tb/tb_demux_1to7_deser.sv
// tb/tb_demux_1to7_deser.sv - scoreboard bench for demux_1to7_deser
module tb_demux_1to7_deser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] sel = 3'd0;
  logic       clear = 1'b0;
  logic [6:0] slots;
  logic [6:0] frame;
  logic       frame_valid;
  logic [2:0] slot_idx;
  logic       sel_err;

  int total = 0;
  int bad   = 0;

  logic [6:0] exp_frame_q[$];
  int         exp_err_q[$];

  always #5 clk = ~clk;

  demux_1to7_deser dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_din         (din),
    .i_din_valid   (din_valid),
    .i_mode        (mode),
    .i_sel         (sel),
    .i_clear       (clear),
    .o_slots       (slots),
    .o_frame       (frame),
    .o_frame_valid (frame_valid),
    .o_slot_idx    (slot_idx),
    .o_sel_err     (sel_err)
  );

  // Scoreboard monitor: every pulse must match an entry pushed by the stimulus.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      total++;
      if (exp_frame_q.size() == 0) begin
        bad++;
        $display("FAIL frame_pulse unexpected frame_valid frame=%b", frame);
      end else begin
        logic [6:0] e;
        e = exp_frame_q.pop_front();
        if (frame !== e) begin
          bad++;
          $display("FAIL frame_data got=%b exp=%b", frame, e);
        end
      end
    end
    if (sel_err === 1'b1) begin
      total++;
      if (exp_err_q.size() == 0) begin
        bad++;
        $display("FAIL sel_err_pulse unexpected sel_err");
      end else begin
        void'(exp_err_q.pop_front());
      end
    end
    if (frame_valid === 1'b1 && sel_err === 1'b1) begin
      total++;
      bad++;
      $display("FAIL pulse_excl frame_valid=1 sel_err=1 exp not both");
    end
  end

  // Applies inputs for one rising edge; returns at the following negedge.
  task automatic cyc(input logic v, input logic d, input logic m,
                     input logic [2:0] s, input logic c, input logic r);
    din_valid = v;
    din       = d;
    mode      = m;
    sel       = s;
    clear     = c;
    reset     = r;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    cyc(1, 1, 1, 3'd0, 0, 1);
    cyc(1, 1, 1, 3'd0, 0, 1);
    total++;
    if (slots !== 7'b0 || frame !== 7'b0 || slot_idx !== 3'd0 ||
        frame_valid !== 1'b0 || sel_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state slots=%b frame=%b idx=%0d fv=%b err=%b exp all zero",
               slots, frame, slot_idx, frame_valid, sel_err);
    end
    cyc(1, 1, 1, 3'd0, 0, 0);
    total++;
    if (slots !== 7'b0000001) begin
      bad++;
      $display("FAIL reset_first_slot got=%b exp=%b", slots, 7'b0000001);
    end
    chk("reset_first_idx", int'(slot_idx), 1);
    cyc(0, 0, 1, 3'd0, 1, 0);
  endtask

  task automatic test_addressed;
    cyc(0, 0, 0, 3'd0, 0, 0);
    cyc(1, 1, 0, 3'd0, 0, 0);
    cyc(1, 1, 0, 3'd3, 0, 0);
    cyc(1, 1, 0, 3'd6, 0, 0);
    chk("addr_slots", int'(slots), int'(7'b1001001));
    exp_err_q.push_back(1);
    cyc(1, 1, 0, 3'd7, 0, 0);
    chk("addr_sel7_slots", int'(slots), int'(7'b1001001));
    chk("addr_sel7_err", int'(sel_err), 1);
    cyc(0, 0, 0, 3'd0, 0, 0);
    chk("addr_err_one_cycle", int'(sel_err), 0);
    chk("addr_idx_hold", int'(slot_idx), 0);
  endtask

  task automatic run_frame(input logic [6:0] bits, input int gap_after, input int gap_len);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) exp_frame_q.push_back(bits);
      cyc(1, bits[i], 1, 3'd0, 0, 0);
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          cyc(0, 1, 1, 3'd0, 0, 0);
          chk("gap_idx_frozen", int'(slot_idx), i + 1);
        end
      end
    end
  endtask

  task automatic test_auto_frame;
    cyc(0, 0, 1, 3'd0, 1, 0);
    run_frame(7'b1001101, -1, 0);
    chk("auto_frame", int'(frame), int'(7'b1001101));
    chk("auto_fv", int'(frame_valid), 1);
    chk("auto_idx_wrap", int'(slot_idx), 0);
    cyc(0, 0, 1, 3'd0, 0, 0);
    chk("auto_fv_one_cycle", int'(frame_valid), 0);
  endtask

  task automatic test_gapped;
    run_frame(7'b1001101, 2, 3);
    chk("gapped_frame", int'(frame), int'(7'b1001101));
    chk("gapped_idx", int'(slot_idx), 0);
  endtask

  task automatic test_mode_switch;
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 3'd0, 0, 0);
    chk("sw_idx_before", int'(slot_idx), 4);
    cyc(1, 0, 0, 3'd0, 0, 0);
    cyc(1, 0, 1, 3'd0, 0, 0);
    chk("sw_idx_reset", int'(slot_idx), 0);
    chk("sw_slots_kept", int'(slots), int'(7'b1001111));
    chk("sw_frame_kept", int'(frame), int'(7'b1001101));
    run_frame(7'b0101010, -1, 0);
    chk("sw_new_frame", int'(frame), int'(7'b0101010));
  endtask

  task automatic test_back_to_back;
    logic [6:0] f;
    for (int k = 0; k < 3; k++) begin
      f = 7'($urandom_range(0, 127));
      run_frame(f, -1, 0);
      chk("b2b_frame", int'(frame), int'(f));
    end
  endtask

  task automatic test_clear_reset;
    logic [6:0] kept;
    kept = frame;
    cyc(1, 1, 1, 3'd0, 0, 0);
    cyc(1, 1, 1, 3'd0, 1, 0);
    chk("clr_slots", int'(slots), 0);
    chk("clr_idx", int'(slot_idx), 0);
    chk("clr_frame_kept", int'(frame), int'(kept));
    cyc(1, 1, 1, 3'd0, 0, 0);
    chk("clr_next_slot0", int'(slots), 1);
    cyc(1, 1, 1, 3'd0, 1, 1);
    chk("clr_rst_frame", int'(frame), 0);
    chk("clr_rst_slots", int'(slots), 0);
    cyc(0, 0, 1, 3'd0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_addressed();
    test_auto_frame();
    test_gapped();
    test_mode_switch();
    test_back_to_back();
    test_clear_reset();
    repeat (3) cyc(0, 0, 1, 3'd0, 0, 0);
    chk("sb_frames_drained", exp_frame_q.size(), 0);
    chk("sb_errs_drained", exp_err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_1to7_deser.md
Name: demux_1to7_deser

Overview:
- Inverse of the board's 7-to-1 select path: one serial input bit is steered into one of 7 registered output slots.
- Two modes. Addressed mode writes the bit to the slot given by sel. Auto mode writes to an internal slot counter that sweeps 0..6 and publishes a completed 7-bit frame.
- Sits between a switch/serial source and LEDR-style parallel outputs in the lab top level.

Parameters:
- NUM_SLOTS, 7, number of output slots; legal range 2..2**SEL_W-1.
- SEL_W, 3, width of the slot select and the slot counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- din  in  1  serial data bit.
- din_valid  in  1  din is consumed this cycle.
- mode  in  1  0 = addressed, 1 = auto-sweep.
- sel  in  SEL_W  target slot in addressed mode; ignored in auto mode.
- clear  in  1  synchronous clear of slots and counter; reset has priority over clear.
- slots  out  NUM_SLOTS  live slot register.
- frame  out  NUM_SLOTS  last completed auto-mode frame; held until the next completion.
- frame_valid  out  1  one-cycle pulse, same cycle frame updates.
- slot_idx  out  SEL_W  current auto-mode slot counter.
- sel_err  out  1  one-cycle pulse for an addressed write with sel >= NUM_SLOTS.

Behaviour:
- Reset (sync, active-high), effective on the next rising edge:
  - slots = 0, frame = 0, slot_idx = 0.
  - frame_valid = 0, sel_err = 0.
  - The internal mode_q copy of mode is loaded with the current mode.
- clear, when reset = 0: slots = 0, slot_idx = 0, pulses deasserted. frame is kept. A din_valid in the same cycle is dropped.
- Addressed mode (mode = 0), din_valid = 1:
  - If sel < NUM_SLOTS: slots[sel] <= din. Visible one cycle later. Other bits unchanged.
  - If sel >= NUM_SLOTS (7 at default): no write, sel_err = 1 for one cycle. This mirrors the mux default-0 case.
  - slot_idx holds.
- Auto mode (mode = 1), din_valid = 1:
  - slots[slot_idx] <= din.
  - If slot_idx == NUM_SLOTS-1: slot_idx <= 0, frame <= slots with bit NUM_SLOTS-1 replaced by din (the same-cycle bit is included), frame_valid = 1 next cycle.
  - Otherwise slot_idx <= slot_idx + 1.
  - slot_idx never reaches NUM_SLOTS; explicit wrap, no reliance on SEL_W overflow.
- din_valid = 0: no state change; pulses low.
- Mode change:
  - mode_q registers mode each cycle.
  - When mode != mode_q, slot_idx <= 0 and any din_valid that cycle is dropped. A partial frame is abandoned and frame is not updated.
  - slots keeps its contents.
- Outputs: all are registered; no combinational path from inputs to outputs.
- frame_valid and sel_err: never asserted in the same cycle; sel_err only in mode 0, frame_valid only in mode 1.
- Back-to-back valids: one bit per cycle, sustained. Full 7-bit frame every 7 valid cycles, so frame_valid can repeat every 7 cycles.
- Reset mid-frame: partial frame discarded and frame zeroed. First valid after reset goes to slot 0.
- Priority per cycle: reset > clear > mode-change drop > write.

Decomposition:
- Shared package demux_pkg: NUM_SLOTS_DEFAULT = 7, SEL_W_DEFAULT = 3, mode encodings MODE_ADDR = 1'b0 and MODE_AUTO = 1'b1.
- Sub-module slot_counter: mod-NUM_SLOTS counter with inc, clr and wrap outputs, used for slot_idx. Everything else stays inline.

Test Plan:
- Reset check: reset high 2 cycles with din_valid = 1 -> slots = 0, frame = 0, slot_idx = 0, no pulses. First auto valid after release writes slot 0.
- Addressed writes: mode = 0, write din = 1 to sel = 0, 3, 6 -> slots = 7'b1001001. sel = 7 with din = 1 -> slots unchanged, sel_err high exactly 1 cycle.
- Auto frame: mode = 1, 7 consecutive valids with din = 1,0,1,1,0,0,1 (slot 0 first) -> frame = 7'b1001101, frame_valid pulse on the cycle after the 7th valid, slot_idx back to 0.
- Gapped valids: same pattern with din_valid low for 3 cycles between bits 2 and 3 -> identical frame, slot_idx frozen during the gaps.
- Mode switch mid-frame: after 4 auto bits, set mode = 0 for 1 cycle with din_valid = 1, then back to 1 -> both switch cycles' bits dropped, slot_idx = 0, frame unchanged, next 7 bits form a new frame.
- Clear and reset priority: clear with din_valid = 1 -> slots = 0, frame retained. clear and reset together -> frame also 0.
